// File: rtl/keypad_operand_entry.sv
// Keypad operand entry: turns debounced key presses into two decimal operands,
// an operator and a request/done handshake with the arithmetic unit.
module keypad_operand_entry #(
    parameter int WIDTH      = 16,
    parameter int MAX_DIGITS = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             validPress,
    input  logic [4:0]       button,
    output logic             calc_req,
    output logic [WIDTH-1:0] operand_a,
    output logic [WIDTH-1:0] operand_b,
    output logic [1:0]       op_sel,
    input  logic             calc_done,
    input  logic [WIDTH-1:0] calc_result,
    output logic [WIDTH-1:0] display_value,
    output logic [1:0]       entry_state
);

    localparam int CW = $clog2(MAX_DIGITS + 1);

    typedef enum logic [1:0] {
        ENTER_A     = 2'd0,
        ENTER_B     = 2'd1,
        WAIT_CALC   = 2'd2,
        SHOW_RESULT = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, disp_q, disp_d;
    logic [1:0]       op_q, op_d;
    logic [CW-1:0]    count_q, count_d;
    logic             req_q, req_d;
    logic             b_typed_q, b_typed_d;
    logic             press_q;

    logic             press_evt, key_digit, key_op, key_clear, key_equals;
    logic [3:0]       digit;
    logic [4:0]       op_wide;
    logic [1:0]       op_code;
    logic [WIDTH-1:0] cur, acc;
    logic [WIDTH+3:0] acc_wide;
    logic             can_add;
    logic [CW-1:0]    count_inc;

    // One event per press: only the rising edge of validPress counts.
    assign press_evt  = validPress && !press_q;
    assign key_digit  = (button <= 5'd9);
    assign key_op     = (button >= 5'd10) && (button <= 5'd12);
    assign key_clear  = (button == 5'd13);
    assign key_equals = (button == 5'd14);
    assign digit      = button[3:0];
    assign op_wide    = button - 5'd10;
    assign op_code    = op_wide[1:0];

    // Widened by 4 bits so cur*10+d never wraps before truncation.
    assign cur       = (state_q == ENTER_B) ? b_q : a_q;
    assign acc_wide  = ({4'b0000, cur} * (WIDTH+4)'(10)) + (WIDTH+4)'(digit);
    assign acc       = acc_wide[WIDTH-1:0];
    assign can_add   = (count_q < CW'(MAX_DIGITS));
    assign count_inc = ((cur == '0) && (digit == 4'd0)) ? count_q : count_q + CW'(1);

    // NOTE: every next-state variable is defaulted to its current value first,
    // so no path through the case statement can leave one unassigned (latch).
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        op_d      = op_q;
        disp_d    = disp_q;
        count_d   = count_q;
        req_d     = req_q;
        b_typed_d = b_typed_q;

        if (press_evt && key_clear) begin
            state_d   = ENTER_A;
            a_d       = '0;
            b_d       = '0;
            op_d      = 2'd0;
            disp_d    = '0;
            count_d   = '0;
            req_d     = 1'b0;
            b_typed_d = 1'b0;
        end else begin
            unique case (state_q)
                ENTER_A, ENTER_B: begin
                    if (press_evt && key_digit) begin
                        b_typed_d = 1'b1;
                        if (can_add) begin
                            if (state_q == ENTER_B) b_d = acc;
                            else                    a_d = acc;
                            count_d = count_inc;
                            disp_d  = acc;
                        end
                    end else if (press_evt && key_op) begin
                        if (state_q == ENTER_A) begin
                            op_d      = op_code;
                            state_d   = ENTER_B;
                            b_d       = '0;
                            count_d   = '0;
                            b_typed_d = 1'b0;
                        end else if (!b_typed_q) begin
                            op_d = op_code;
                        end
                    end else if (press_evt && key_equals && state_q == ENTER_B && b_typed_q) begin
                        state_d = WAIT_CALC;
                        req_d   = 1'b1;
                    end
                end
                WAIT_CALC: begin
                    if (calc_done) begin
                        req_d   = 1'b0;
                        disp_d  = calc_result;
                        a_d     = calc_result;
                        state_d = SHOW_RESULT;
                    end
                end
                SHOW_RESULT: begin
                    if (press_evt && key_digit) begin
                        a_d       = WIDTH'(digit);
                        count_d   = (digit != 4'd0) ? CW'(1) : '0;
                        disp_d    = WIDTH'(digit);
                        state_d   = ENTER_A;
                        b_typed_d = 1'b0;
                    end else if (press_evt && key_op) begin
                        op_d      = op_code;
                        state_d   = ENTER_B;
                        b_d       = '0;
                        count_d   = '0;
                        b_typed_d = 1'b0;
                    end
                end
                default: state_d = ENTER_A;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= ENTER_A;
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= 2'd0;
            disp_q    <= '0;
            count_q   <= '0;
            req_q     <= 1'b0;
            b_typed_q <= 1'b0;
            press_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            op_q      <= op_d;
            disp_q    <= disp_d;
            count_q   <= count_d;
            req_q     <= req_d;
            b_typed_q <= b_typed_d;
            press_q   <= validPress;
        end
    end

    assign calc_req      = req_q;
    assign operand_a     = a_q;
    assign operand_b     = b_q;
    assign op_sel        = op_q;
    assign display_value = disp_q;
    assign entry_state   = state_q;

endmodule

// File: tb/tb_keypad_operand_entry.sv
// Self-checking bench for keypad_operand_entry: directed vector table,
// multi-cycle corner cases and a randomized run against a behavioural model.
module tb_keypad_operand_entry;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        validPress = 1'b0;
    logic [4:0]  button = '0;
    logic        calc_req;
    logic [15:0] operand_a, operand_b, display_value, calc_result = '0;
    logic [1:0]  op_sel, entry_state;
    logic        calc_done = 1'b0;

    int checks = 0;
    int failures = 0;

    keypad_operand_entry #(.WIDTH(16), .MAX_DIGITS(4)) dut (
        .clock(clock), .reset(reset), .validPress(validPress), .button(button),
        .calc_req(calc_req), .operand_a(operand_a), .operand_b(operand_b),
        .op_sel(op_sel), .calc_done(calc_done), .calc_result(calc_result),
        .display_value(display_value), .entry_state(entry_state)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit          kv;
        logic [4:0]  key;
        bit          done;
        logic [15:0] res;
        logic [15:0] disp;
        logic [1:0]  st;
        bit          req;
        logic [15:0] a;
        logic [15:0] b;
        logic [1:0]  op;
    } vec_t;

    vec_t vecs[$];

    function automatic void add_vec(bit kv, int key, bit done, int res,
                                    int disp, int st, bit req, int a, int b, int op);
        vec_t v;
        v.kv = kv; v.key = 5'(key); v.done = done; v.res = 16'(res);
        v.disp = 16'(disp); v.st = 2'(st); v.req = req;
        v.a = 16'(a); v.b = 16'(b); v.op = 2'(op);
        vecs.push_back(v);
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_all(string tag, int disp, int st, bit req, int a, int b, int op);
        check($sformatf("%s display_value", tag), 32'(display_value), 32'(disp));
        check($sformatf("%s entry_state", tag), 32'(entry_state), 32'(st));
        check($sformatf("%s calc_req", tag), 32'(calc_req), 32'(req));
        check($sformatf("%s operand_a", tag), 32'(operand_a), 32'(a));
        check($sformatf("%s operand_b", tag), 32'(operand_b), 32'(b));
        check($sformatf("%s op_sel", tag), 32'(op_sel), 32'(op));
    endtask

    // One step: inputs live for exactly one rising edge, then a quiet cycle
    // lets the press detector rearm. Outputs are sampled on a falling edge.
    task automatic drive(bit kv, logic [4:0] k, bit d, logic [15:0] r);
        @(negedge clock);
        validPress = kv; button = k; calc_done = d; calc_result = r;
        @(negedge clock);
        validPress = 1'b0; calc_done = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
    endtask

    // Behavioural reference: modes 0=A 1=B 2=wait 3=show
    int          m_mode, m_ndig, m_op;
    int unsigned m_a, m_b, m_disp;
    bit          m_req, m_btyped;

    function automatic void model_clear();
        m_mode = 0; m_ndig = 0; m_op = 0; m_a = 0; m_b = 0; m_disp = 0;
        m_req = 0; m_btyped = 0;
    endfunction

    function automatic void model_key(int k);
        int unsigned v;
        if (k <= 9) begin
            if (m_mode == 3) begin
                m_a = 0; m_ndig = 0; m_mode = 0;
            end
            if (m_mode == 1) m_btyped = 1;
            v = (m_mode == 1) ? m_b : m_a;
            if (m_ndig < 4) begin
                v = v * 10 + k;
                if (v != 0) m_ndig++;
            end
            if (m_mode == 1) m_b = v; else m_a = v;
            m_disp = v;
        end else if (k >= 10 && k <= 12) begin
            if (m_mode == 0 || m_mode == 3) begin
                m_op = k - 10; m_mode = 1; m_b = 0; m_ndig = 0; m_btyped = 0;
            end else if (m_mode == 1 && !m_btyped) begin
                m_op = k - 10;
            end
        end else if (k == 14) begin
            if (m_mode == 1 && m_btyped) begin
                m_mode = 2; m_req = 1;
            end
        end
    endfunction

    function automatic void model_step(bit kv, int k, bit done, int unsigned r);
        if (kv && k == 13) model_clear();
        else if (m_mode == 2) begin
            if (done) begin
                m_req = 0; m_disp = r; m_a = r; m_mode = 3;
            end
        end else if (kv) model_key(k);
    endfunction

    function automatic logic [15:0] alu(int op, int unsigned a, int unsigned b);
        int unsigned r;
        case (op)
            0:       r = a + b;
            1:       r = a - b;
            default: r = a * b;
        endcase
        return r[15:0];
    endfunction

    initial begin
        // Directed table, starting from reset.
        add_vec(1, 1, 0, 0,     1, 0, 0,    1,  0, 0);
        add_vec(1, 2, 0, 0,    12, 0, 0,   12,  0, 0);
        add_vec(1, 3, 0, 0,   123, 0, 0,  123,  0, 0);
        add_vec(1, 14, 0, 0,  123, 0, 0,  123,  0, 0);
        add_vec(1, 13, 0, 0,    0, 0, 0,    0,  0, 0);
        add_vec(1, 1, 0, 0,     1, 0, 0,    1,  0, 0);
        add_vec(1, 2, 0, 0,    12, 0, 0,   12,  0, 0);
        add_vec(1, 10, 0, 0,   12, 1, 0,   12,  0, 0);
        add_vec(1, 14, 0, 0,   12, 1, 0,   12,  0, 0);
        add_vec(1, 3, 0, 0,     3, 1, 0,   12,  3, 0);
        add_vec(1, 4, 0, 0,    34, 1, 0,   12, 34, 0);
        add_vec(1, 11, 0, 0,   34, 1, 0,   12, 34, 0);
        add_vec(1, 14, 0, 0,   34, 2, 1,   12, 34, 0);
        add_vec(1, 5, 0, 0,    34, 2, 1,   12, 34, 0);
        add_vec(0, 0, 1, 46,   46, 3, 0,   46, 34, 0);
        add_vec(0, 0, 1, 77,   46, 3, 0,   46, 34, 0);
        add_vec(1, 14, 0, 0,   46, 3, 0,   46, 34, 0);
        add_vec(1, 12, 0, 0,   46, 1, 0,   46,  0, 2);
        add_vec(1, 2, 0, 0,     2, 1, 0,   46,  2, 2);
        add_vec(1, 14, 0, 0,    2, 2, 1,   46,  2, 2);
        add_vec(1, 7, 1, 92,   92, 3, 0,   92,  2, 2);
        add_vec(1, 9, 0, 0,     9, 0, 0,    9,  2, 2);
        add_vec(1, 9, 0, 0,    99, 0, 0,   99,  2, 2);
        add_vec(1, 9, 0, 0,   999, 0, 0,  999,  2, 2);
        add_vec(1, 9, 0, 0,  9999, 0, 0, 9999,  2, 2);
        add_vec(1, 9, 0, 0,  9999, 0, 0, 9999,  2, 2);
        add_vec(1, 20, 0, 0, 9999, 0, 0, 9999,  2, 2);
        add_vec(1, 13, 0, 0,    0, 0, 0,    0,  0, 0);
        add_vec(1, 0, 0, 0,     0, 0, 0,    0,  0, 0);
        add_vec(1, 0, 0, 0,     0, 0, 0,    0,  0, 0);
        add_vec(1, 7, 0, 0,     7, 0, 0,    7,  0, 0);
        add_vec(1, 1, 0, 0,    71, 0, 0,   71,  0, 0);
        add_vec(1, 2, 0, 0,   712, 0, 0,  712,  0, 0);
        add_vec(1, 3, 0, 0,  7123, 0, 0, 7123,  0, 0);
        add_vec(1, 4, 0, 0,  7123, 0, 0, 7123,  0, 0);
        add_vec(1, 10, 0, 0, 7123, 1, 0, 7123,  0, 0);
        add_vec(1, 11, 0, 0, 7123, 1, 0, 7123,  0, 1);
        add_vec(1, 0, 0, 0,     0, 1, 0, 7123,  0, 1);
        add_vec(1, 5, 0, 0,     5, 1, 0, 7123,  5, 1);
        add_vec(1, 14, 0, 0,    5, 2, 1, 7123,  5, 1);
        add_vec(1, 13, 1, 7118, 0, 0, 0,    0,  0, 0);
        add_vec(0, 0, 1, 55,    0, 0, 0,    0,  0, 0);

        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check_all("reset", 0, 0, 0, 0, 0, 0);

        foreach (vecs[i]) begin
            drive(vecs[i].kv, vecs[i].key, vecs[i].done, vecs[i].res);
            check_all($sformatf("vec%0d", i), vecs[i].disp, vecs[i].st, vecs[i].req,
                      vecs[i].a, vecs[i].b, vecs[i].op);
        end

        // Long press: one level held for 50 cycles yields a single digit.
        do_reset();
        @(negedge clock);
        validPress = 1'b1; button = 5'd5;
        repeat (50) @(negedge clock);
        validPress = 1'b0;
        @(negedge clock);
        check_all("hold50", 5, 0, 0, 5, 0, 0);

        // calc_req must stay high across idle cycles until calc_done.
        drive(1, 5'd10, 0, 0);
        drive(1, 5'd3, 0, 0);
        drive(1, 5'd14, 0, 0);
        repeat (7) @(negedge clock);
        check_all("req_hold", 3, 2, 1, 5, 3, 0);
        drive(0, 5'd0, 1, 16'd8);
        check_all("req_done", 8, 3, 0, 8, 3, 0);

        // Randomized run against the behavioural model.
        do_reset();
        model_clear();
        for (int i = 0; i < 600; i++) begin
            bit          kv, dn;
            int          r, k;
            logic [15:0] res;
            kv = ($urandom_range(0, 9) < 7);
            r  = $urandom_range(0, 99);
            if (r < 60)      k = r % 10;
            else if (r < 75) k = 10 + r % 3;
            else if (r < 79) k = 13;
            else if (r < 89) k = 14;
            else             k = 15 + $urandom_range(0, 16);
            dn  = (m_mode == 2) ? ($urandom_range(0, 9) < 4) : ($urandom_range(0, 9) < 1);
            res = (m_mode == 2) ? alu(m_op, m_a, m_b) : 16'($urandom);
            drive(kv, 5'(k), dn, res);
            model_step(kv, k, dn, res);
            check_all($sformatf("rand%0d", i), m_disp, m_mode, m_req, m_a, m_b, m_op);
        end

        // Asynchronous reset must clear outputs before any clock edge.
        do_reset();
        drive(1, 5'd4, 0, 0);
        drive(1, 5'd12, 0, 0);
        drive(1, 5'd6, 0, 0);
        drive(1, 5'd14, 0, 0);
        check_all("pre_async", 6, 2, 1, 4, 6, 2);
        @(posedge clock);
        #2 reset = 1'b1;
        #1 check_all("async_reset", 0, 0, 0, 0, 0, 0);
        @(negedge clock);
        reset = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
